// File: rtl/video_pkg.sv
// video_pkg: shared defaults for the video pixel path
package video_pkg;
  localparam int PIXEL_BITS_DEFAULT = 4;
  localparam int PIXELS_PER_WORD_DEFAULT = 6;
  localparam logic [PIXEL_BITS_DEFAULT-1:0] BLANK_PIXEL = '0;
endpackage

// File: rtl/video_pair_swap.sv
// video_pair_swap: combinational pixel-pair reorder (screen_control=0 swaps each pair)
module video_pair_swap #(
  parameter int PIXEL_BITS = 4,
  parameter int PIXELS_PER_WORD = 6
) (
  input  logic                                  screen_control,
  input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] word_in,
  output logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] word_out
);
  for (genvar p = 0; p < PIXELS_PER_WORD / 2; p++) begin : g_pair
    assign word_out[2*p*PIXEL_BITS +: PIXEL_BITS] =
      screen_control ? word_in[2*p*PIXEL_BITS +: PIXEL_BITS] : word_in[(2*p+1)*PIXEL_BITS +: PIXEL_BITS];
    assign word_out[(2*p+1)*PIXEL_BITS +: PIXEL_BITS] =
      screen_control ? word_in[(2*p+1)*PIXEL_BITS +: PIXEL_BITS] : word_in[2*p*PIXEL_BITS +: PIXEL_BITS];
  end
endmodule

// File: rtl/video_pixel_serializer.sv
// video_pixel_serializer: hold buffer + shifter emitting one pixel per pixel_en; option VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN adds underrun_count
module video_pixel_serializer
  import video_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DEFAULT,
  parameter int PIXELS_PER_WORD = PIXELS_PER_WORD_DEFAULT,
  parameter logic [PIXEL_BITS-1:0] BLANK_VALUE = PIXEL_BITS'(BLANK_PIXEL)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  screen_control,
  input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  pixel_en,
  output logic [PIXEL_BITS-1:0]                 pixel_out,
  output logic                                  pixel_valid,
  output logic                                  underrun
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                           underrun_count
`endif
);
  localparam int W = PIXEL_BITS * PIXELS_PER_WORD;
  localparam int CW = $clog2(PIXELS_PER_WORD + 1);
  localparam logic [CW-1:0] FULL = CW'(PIXELS_PER_WORD);
  if ((PIXELS_PER_WORD % 2) != 0 || PIXELS_PER_WORD < 2) begin : g_bad_ppw
    $error("video_pixel_serializer: PIXELS_PER_WORD must be even and >= 2");
  end
  logic [W-1:0]  swapped, hold, shifter;
  logic          hold_valid, transfer, accept, empty_strobe;
  logic [CW-1:0] count;
  video_pair_swap #(.PIXEL_BITS(PIXEL_BITS), .PIXELS_PER_WORD(PIXELS_PER_WORD)) u_swap (
    .screen_control(screen_control),
    .word_in(in_data),
    .word_out(swapped)
  );
  assign transfer = hold_valid && (count == '0 || (pixel_en && count == CW'(1)));
  assign in_ready = !hold_valid || transfer;
  assign accept = in_valid && in_ready;
  assign empty_strobe = pixel_en && count == '0;
  assign pixel_out = shifter[PIXEL_BITS-1:0];
  assign pixel_valid = count != '0;
  // hold register: capture reordered word on accept, release it on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= {PIXELS_PER_WORD{BLANK_VALUE}};
      hold_valid <= 1'b0;
    end else begin
      if (accept) hold <= swapped;
      hold_valid <= accept || (hold_valid && !transfer);
    end
  end
  // shifter: load from hold, otherwise shift toward slot 0 with blank fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter <= {PIXELS_PER_WORD{BLANK_VALUE}};
      count <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= empty_strobe;
      if (transfer) begin
        shifter <= hold;
        count <= FULL;
      end else if (pixel_en && count != '0) begin
        shifter <= {BLANK_VALUE, shifter[W-1:PIXEL_BITS]};
        count <= count - CW'(1);
      end
    end
  end
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
  // saturating count of strobes that found the shifter empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_count <= '0;
    else if (empty_strobe && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_video_pixel_serializer.sv
// tb_video_pixel_serializer: directed scoreboard bench for video_pixel_serializer
module tb_video_pixel_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        screen_control = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        pixel_en = 1'b0;
  logic [3:0]  pixel_out;
  logic        pixel_valid;
  logic        underrun;
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
  logic [15:0] underrun_count;
`endif
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  q[$];

  video_pixel_serializer dut (
    .clk(clk),
    .rst_n(rst_n),
    .screen_control(screen_control),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pixel_en(pixel_en),
    .pixel_out(pixel_out),
    .pixel_valid(pixel_valid),
    .underrun(underrun)
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [23:0] w, input logic sc);
    for (int i = 0; i < 6; i++) begin
      int j;
      j = sc ? i : (i ^ 1);
      q.push_back(w[j*4 +: 4]);
    end
  endtask

  task automatic monitor();
    logic [3:0] e;
    if (rst_n && pixel_en && pixel_valid) begin
      if (q.size() == 0) chk("extra_pixel", 32'(pixel_out), 32'hDEAD);
      else begin
        e = q.pop_front();
        chk("pixel", 32'(pixel_out), 32'(e));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] w, input logic sc);
    bit done;
    done = 0;
    in_data = w;
    screen_control = sc;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        push_word(w, sc);
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    pixel_en = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    pixel_en = 1'b0;
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_pixel_out", 32'(pixel_out), 32'h0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_underrun", 32'(underrun), 32'h0);
    rst_n = 1'b1;
    tick();
    // async reset mid-word
    send(24'h654321, 1'b1);
    tick();
    pixel_en = 1'b1;
    tick();
    tick();
    chk("pre_rst_pixel", 32'(pixel_out), 32'h3);
    send(24'hABCDEF, 1'b1);
    #2 rst_n = 1'b0;
    pixel_en = 1'b0;
    #1;
    chk("async_rst_pixel_out", 32'(pixel_out), 32'h0);
    chk("async_rst_pixel_valid", 32'(pixel_valid), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h1);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(pixel_valid), 32'h0);
    // natural order
    send(24'h654321, 1'b1);
    tick();
    chk("sc1_first_valid", 32'(pixel_valid), 32'h1);
    chk("sc1_first_pixel", 32'(pixel_out), 32'h1);
    pixel_en = 1'b1;
    repeat (6) tick();
    pixel_en = 1'b0;
    chk("sc1_end_valid", 32'(pixel_valid), 32'h0);
    chk("sc1_end_blank", 32'(pixel_out), 32'h0);
    chk("sc1_q_empty", 32'(q.size()), 32'd0);
    chk("sc1_no_underrun", 32'(underrun), 32'h0);
    // pair-swapped order
    send(24'h654321, 1'b0);
    tick();
    chk("sc0_first_pixel", 32'(pixel_out), 32'h2);
    pixel_en = 1'b1;
    repeat (6) tick();
    pixel_en = 1'b0;
    chk("sc0_end_valid", 32'(pixel_valid), 32'h0);
    chk("sc0_q_empty", 32'(q.size()), 32'd0);
    // back-to-back words, continuous output
    send(24'h123456, 1'b1);
    tick();
    pixel_en = 1'b1;
    chk("b2b_valid_1", 32'(pixel_valid), 32'h1);
    send(24'h9ABCDE, 1'b0);
    for (int k = 2; k <= 12; k++) begin
      chk("b2b_in_ready", 32'(in_ready), 32'(k >= 6));
      chk("b2b_valid", 32'(pixel_valid), 32'h1);
      chk("b2b_underrun", 32'(underrun), 32'h0);
      tick();
    end
    pixel_en = 1'b0;
    chk("b2b_end_valid", 32'(pixel_valid), 32'h0);
    chk("b2b_end_underrun", 32'(underrun), 32'h0);
    chk("b2b_q_empty", 32'(q.size()), 32'd0);
    // underrun pulse
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
    chk("ucnt_start", 32'(underrun_count), 32'h0);
`endif
    pixel_en = 1'b1;
    tick();
    pixel_en = 1'b0;
    chk("underrun_pulse", 32'(underrun), 32'h1);
    chk("underrun_no_valid", 32'(pixel_valid), 32'h0);
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
    chk("ucnt_one", 32'(underrun_count), 32'h1);
`endif
    tick();
    chk("underrun_clear", 32'(underrun), 32'h0);
`ifdef VIDEO_PIXEL_SERIALIZER_UNDERRUN_COUNT_EN
    chk("ucnt_hold", 32'(underrun_count), 32'h1);
    pixel_en = 1'b1;
    for (int i = 0; i < 70000 && underrun_count != 16'hFFFF; i++) tick();
    chk("ucnt_reach_max", 32'(underrun_count), 32'hFFFF);
    repeat (3) tick();
    chk("ucnt_saturate", 32'(underrun_count), 32'hFFFF);
    pixel_en = 1'b0;
    tick();
`endif
    // offer while hold full and shifter at count 3
    send(24'h111111 * 24'd3, 1'b1);
    tick();
    send(24'hFEDCBA, 1'b0);
    pixel_en = 1'b1;
    repeat (3) tick();
    pixel_en = 1'b0;
    in_data = 24'h777777;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    pixel_en = 1'b1;
    send(24'h2468AC, 1'b1);
    drain();
    chk("full_end_valid", 32'(pixel_valid), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
